// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES job sequencer: FSM/mode encodings, config payload, round lookup.
package aes_pkg;

    localparam int unsigned HCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INV_TRANS  = 3'd1,
        ST_KEY_EXPAND = 3'd2,
        ST_WAIT_IN    = 3'd3,
        ST_ROUNDS     = 3'd4,
        ST_WAIT_OUT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_ECB  = 2'd0,
        MODE_CBC  = 2'd1,
        MODE_CTR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam logic [1:0] NK_128 = 2'd0;
    localparam logic [1:0] NK_192 = 2'd1;
    localparam logic [1:0] NK_256 = 2'd2;

    typedef struct packed {
        logic [1:0] nk;
        logic       inv;
        mode_e      mode;
    } cfg_t;

    // Number of full rounds for a key size; encodings 2 and 3 both mean AES-256.
    function automatic logic [HCNT_W-1:0] nr_of(input logic [1:0] nk);
        if (nk >= NK_256) return 4'd14;
        if (nk == NK_192) return 4'd12;
        return 4'd10;
    endfunction

    // CTR always runs the cipher forward, so the inverse flag only matters otherwise.
    function automatic logic eff_inv_of(input cfg_t c);
        return c.inv & (c.mode != MODE_CTR);
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round (hcnt) and in-round cycle (lcnt) counter; round 0 lasts one cycle, later rounds ROUND_CYCLES.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES = 8,
    parameter int unsigned LCNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    input  logic [HCNT_W-1:0] nr,
    output logic [HCNT_W-1:0] hcnt,
    output logic [HCNT_W-1:0] hcnt_nxt_c,
    output logic [LCNT_W-1:0] lcnt_nxt_c,
    output logic              last_c
);

    logic [LCNT_W-1:0] lcnt_q;
    logic              lcnt_wrap;

    assign lcnt_wrap = (lcnt_q == LCNT_W'(ROUND_CYCLES - 1));
    assign last_c    = (hcnt == nr) && lcnt_wrap;

    always_comb begin
        hcnt_nxt_c = hcnt;
        lcnt_nxt_c = lcnt_q;
        if (clear) begin
            hcnt_nxt_c = '0;
            lcnt_nxt_c = '0;
        end else if (run) begin
            if (hcnt == '0 || lcnt_wrap) begin
                hcnt_nxt_c = hcnt + HCNT_W'(1);
                lcnt_nxt_c = '0;
            end else begin
                lcnt_nxt_c = lcnt_q + LCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            lcnt_q <= '0;
        end else begin
            hcnt   <= hcnt_nxt_c;
            lcnt_q <= lcnt_nxt_c;
        end
    end

endmodule

// File: rtl/aes_job_sequencer.sv
// AES job sequencer: key expansion, round-key direction changes and multi-block ECB/CBC/CTR jobs
// with valid/ready handshakes toward the round datapath.
module aes_job_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES = 8,
    parameter int unsigned INV_CYCLES   = 2,
    parameter int unsigned KE_LAT       = 2,
    parameter int unsigned KE_LAT_INV   = 3,
    parameter int unsigned BLK_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_nk,
    input  logic             cfg_inv,
    input  logic [1:0]       cfg_mode,
    input  logic             ke_req,
    input  logic             ke_last,
    input  logic             job_start,
    input  logic [BLK_W-1:0] job_blocks,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       state,
    output logic             key_ready,
    output logic             job_done,
    output logic             job_err,
    output logic [3:0]       round_idx,
    output logic             rkd_inv_flag,
    output logic             rkd_shift,
    output logic             ie_load,
    output logic             ie_last_round,
    output logic             chain_xor_in,
    output logic             chain_xor_out,
    output logic             ctr_inc
);

    localparam int unsigned LCNT_W = $clog2(ROUND_CYCLES);
    localparam int unsigned DCNT_W = 4;

    state_e             state_q, state_d;
    cfg_t               cfg_q, cfg_d, cfg_new;
    logic [BLK_W-1:0]   blocks_left_q, blocks_left_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d, ke_lat;
    logic               ke_pend_q, ke_pend_d;
    logic               key_ready_d, rkd_inv_flag_d, rkd_shift_d, job_done_d, job_err_d, ctr_inc_d;
    logic               in_ready_d, out_valid_d, ie_load_d, ie_last_round_d;
    logic               chain_xor_in_d, chain_xor_out_d, job_active;
    logic               eff_inv, in_acc, out_acc, job_state;
    logic               cnt_clear, cnt_run, cnt_last;
    logic [HCNT_W-1:0]  nr, hcnt, hcnt_nxt;
    logic [LCNT_W-1:0]  lcnt_nxt;

    assign cfg_new   = '{nk: cfg_nk, inv: cfg_inv, mode: mode_e'(cfg_mode)};
    assign eff_inv   = eff_inv_of(cfg_q);
    assign nr        = nr_of(cfg_q.nk);
    assign ke_lat    = eff_inv ? DCNT_W'(KE_LAT_INV) : DCNT_W'(KE_LAT);
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    assign job_state = (state_q == ST_WAIT_IN) || (state_q == ST_ROUNDS) || (state_q == ST_WAIT_OUT);
    assign state     = state_q;
    assign round_idx = hcnt;

    // Counter controls depend only on registered state and inputs, keeping the next-state logic acyclic.
    assign cnt_clear = (job_state && abort) || (state_q == ST_WAIT_IN && in_acc);
    assign cnt_run   = (state_q == ST_ROUNDS) && !abort && !cnt_last;

    aes_round_counter #(
        .ROUND_CYCLES (ROUND_CYCLES),
        .LCNT_W       (LCNT_W)
    ) u_round_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .run        (cnt_run),
        .nr         (nr),
        .hcnt       (hcnt),
        .hcnt_nxt_c (hcnt_nxt),
        .lcnt_nxt_c (lcnt_nxt),
        .last_c     (cnt_last)
    );

    always_comb begin
        state_d         = state_q;
        cfg_d           = cfg_q;
        blocks_left_d   = blocks_left_q;
        dcnt_d          = dcnt_q;
        ke_pend_d       = ke_pend_q;
        key_ready_d     = key_ready;
        rkd_inv_flag_d  = rkd_inv_flag;
        rkd_shift_d     = 1'b0;
        job_done_d      = 1'b0;
        job_err_d       = 1'b0;
        ctr_inc_d       = 1'b0;
        job_active      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    cfg_d = cfg_new;
                    if (cfg_new.nk != cfg_q.nk) key_ready_d = 1'b0;
                end
                if (cfg_valid && (eff_inv_of(cfg_new) != eff_inv)) begin
                    state_d        = ST_INV_TRANS;
                    dcnt_d         = '0;
                    rkd_inv_flag_d = ~rkd_inv_flag;
                    rkd_shift_d    = 1'b1;
                end else if (ke_req) begin
                    state_d     = ST_KEY_EXPAND;
                    key_ready_d = 1'b0;
                    ke_pend_d   = 1'b0;
                end else if (job_start) begin
                    if (key_ready && job_blocks != '0) begin
                        state_d       = ST_WAIT_IN;
                        blocks_left_d = job_blocks;
                    end else begin
                        job_err_d = 1'b1;
                    end
                end
            end
            ST_INV_TRANS: begin
                if (dcnt_q >= DCNT_W'(INV_CYCLES - 1)) state_d = ST_IDLE;
                else                                   dcnt_d  = dcnt_q + DCNT_W'(1);
            end
            // ke_last starts the settle delay; the decrypt store also needs one advance afterwards.
            ST_KEY_EXPAND: begin
                if (!ke_pend_q) begin
                    if (ke_last) begin
                        ke_pend_d   = 1'b1;
                        dcnt_d      = DCNT_W'(1);
                        rkd_shift_d = eff_inv;
                    end
                end else if (dcnt_q >= ke_lat) begin
                    ke_pend_d   = 1'b0;
                    key_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            ST_WAIT_IN: begin
                if (abort) begin
                    state_d       = ST_IDLE;
                    blocks_left_d = '0;
                end else if (in_acc) begin
                    state_d   = ST_ROUNDS;
                    ctr_inc_d = (cfg_q.mode == MODE_CTR);
                end
            end
            ST_ROUNDS: begin
                if (abort) begin
                    state_d       = ST_IDLE;
                    blocks_left_d = '0;
                end else if (cnt_last) begin
                    state_d = ST_WAIT_OUT;
                end else begin
                    rkd_shift_d = (lcnt_nxt == LCNT_W'(2));
                end
            end
            ST_WAIT_OUT: begin
                if (abort) begin
                    state_d       = ST_IDLE;
                    blocks_left_d = '0;
                end else if (out_acc) begin
                    blocks_left_d = blocks_left_q - BLK_W'(1);
                    if (blocks_left_q == BLK_W'(1)) begin
                        state_d    = ST_IDLE;
                        job_done_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_IN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        job_active      = (state_d == ST_WAIT_IN) || (state_d == ST_ROUNDS) || (state_d == ST_WAIT_OUT);
        in_ready_d      = (state_d == ST_WAIT_IN);
        out_valid_d     = (state_d == ST_WAIT_OUT);
        ie_load_d       = (state_d != ST_ROUNDS);
        ie_last_round_d = (state_d == ST_ROUNDS) && (hcnt_nxt == nr);
        chain_xor_in_d  = job_active && (cfg_q.mode == MODE_CBC) && !eff_inv;
        chain_xor_out_d = job_active && ((cfg_q.mode == MODE_CTR) || ((cfg_q.mode == MODE_CBC) && eff_inv));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '{nk: NK_128, inv: 1'b0, mode: MODE_ECB};
            blocks_left_q <= '0;
            dcnt_q        <= '0;
            ke_pend_q     <= 1'b0;
            key_ready     <= 1'b0;
            rkd_inv_flag  <= 1'b0;
            rkd_shift     <= 1'b0;
            job_done      <= 1'b0;
            job_err       <= 1'b0;
            ctr_inc       <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            ie_load       <= 1'b1;
            ie_last_round <= 1'b0;
            chain_xor_in  <= 1'b0;
            chain_xor_out <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            blocks_left_q <= blocks_left_d;
            dcnt_q        <= dcnt_d;
            ke_pend_q     <= ke_pend_d;
            key_ready     <= key_ready_d;
            rkd_inv_flag  <= rkd_inv_flag_d;
            rkd_shift     <= rkd_shift_d;
            job_done      <= job_done_d;
            job_err       <= job_err_d;
            ctr_inc       <= ctr_inc_d;
            in_ready      <= in_ready_d;
            out_valid     <= out_valid_d;
            ie_load       <= ie_load_d;
            ie_last_round <= ie_last_round_d;
            chain_xor_in  <= chain_xor_in_d;
            chain_xor_out <= chain_xor_out_d;
        end
    end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer: key expansion timing, ECB/CTR/CBC-decrypt jobs,
// backpressure, abort and reset, all against hand-derived cycle counts.
module tb_aes_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_inv, ke_req, ke_last, job_start, abort, in_valid, out_ready;
    logic [1:0]  cfg_nk, cfg_mode;
    logic [15:0] job_blocks;
    logic        in_ready, out_valid, key_ready, job_done, job_err;
    logic        rkd_inv_flag, rkd_shift, ie_load, ie_last_round, chain_xor_in, chain_xor_out, ctr_inc;
    logic [2:0]  state;
    logic [3:0]  round_idx;

    int vec  = 0;
    int errs = 0;

    aes_job_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_nk        (cfg_nk),
        .cfg_inv       (cfg_inv),
        .cfg_mode      (cfg_mode),
        .ke_req        (ke_req),
        .ke_last       (ke_last),
        .job_start     (job_start),
        .job_blocks    (job_blocks),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .state         (state),
        .key_ready     (key_ready),
        .job_done      (job_done),
        .job_err       (job_err),
        .round_idx     (round_idx),
        .rkd_inv_flag  (rkd_inv_flag),
        .rkd_shift     (rkd_shift),
        .ie_load       (ie_load),
        .ie_last_round (ie_last_round),
        .chain_xor_in  (chain_xor_in),
        .chain_xor_out (chain_xor_out),
        .ctr_inc       (ctr_inc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] blocks);
        job_blocks = blocks;
        job_start  = 1'b1;
        tick();
        job_start  = 1'b0;
    endtask

    task automatic push_block();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_in(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_out(output int n, output int n_shift, output int n_last, output int n_inc);
        n = 0; n_shift = 0; n_last = 0; n_inc = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
            n_shift += int'(rkd_shift);
            n_last  += int'(ie_last_round);
            n_inc   += int'(ctr_inc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vec++;
        if (state !== 3'd0 || round_idx !== 4'd0) begin
            errs++; $display("FAIL reset_state: state=%0d round=%0d, want 0/0", state, round_idx);
        end
        vec++;
        if ({key_ready, in_ready, out_valid, ie_load} !== 4'b0001) begin
            errs++; $display("FAIL reset_hs: key_ready/in_ready/out_valid/ie_load=%b, want 0001",
                             {key_ready, in_ready, out_valid, ie_load});
        end
        vec++;
        if ({rkd_inv_flag, rkd_shift, job_done, job_err, ctr_inc, chain_xor_in, chain_xor_out, ie_last_round} !== 8'h00) begin
            errs++; $display("FAIL reset_flags: flags=%b, want 00000000",
                             {rkd_inv_flag, rkd_shift, job_done, job_err, ctr_inc, chain_xor_in, chain_xor_out, ie_last_round});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_job_err(input logic [15:0] blocks, input string tag);
        start_job(blocks);
        vec++;
        if (job_err !== 1'b1 || state !== 3'd0) begin
            errs++; $display("FAIL %s: job_err=%b state=%0d, want 1/0", tag, job_err, state);
        end
        tick();
        vec++;
        if (job_err !== 1'b0) begin
            errs++; $display("FAIL %s_pulse: job_err=%b, want 0", tag, job_err);
        end
    endtask

    task automatic test_key_expand(input int lat, input logic exp_shift);
        ke_req = 1'b1;
        tick();
        ke_req = 1'b0;
        vec++;
        if (state !== 3'd2 || key_ready !== 1'b0) begin
            errs++; $display("FAIL ke_enter: state=%0d key_ready=%b, want 2/0", state, key_ready);
        end
        ke_last = 1'b1;
        tick();
        ke_last = 1'b0;
        vec++;
        if (rkd_shift !== exp_shift || key_ready !== 1'b0) begin
            errs++; $display("FAIL ke_shift: rkd_shift=%b key_ready=%b, want %b/0", rkd_shift, key_ready, exp_shift);
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            vec++;
            if (key_ready !== 1'b0 || state !== 3'd2) begin
                errs++; $display("FAIL ke_wait%0d: key_ready=%b state=%0d, want 0/2", i, key_ready, state);
            end
        end
        tick();
        vec++;
        if (key_ready !== 1'b1 || state !== 3'd0) begin
            errs++; $display("FAIL ke_done: key_ready=%b state=%0d, want 1/0", key_ready, state);
        end
    endtask

    task automatic test_ecb_single();
        int n, ns, nl, ni;
        out_ready = 1'b1;
        start_job(16'd1);
        vec++;
        if (state !== 3'd3 || in_ready !== 1'b1) begin
            errs++; $display("FAIL ecb_wait_in: state=%0d in_ready=%b, want 3/1", state, in_ready);
        end
        push_block();
        vec++;
        if (state !== 3'd4 || round_idx !== 4'd0 || ie_load !== 1'b0 || ctr_inc !== 1'b0 || chain_xor_in !== 1'b0) begin
            errs++; $display("FAIL ecb_rounds: state=%0d round=%0d ie_load=%b ctr_inc=%b cxi=%b, want 4/0/0/0/0",
                             state, round_idx, ie_load, ctr_inc, chain_xor_in);
        end
        wait_out(n, ns, nl, ni);
        vec++;
        if (n != 81 || round_idx !== 4'd10) begin
            errs++; $display("FAIL ecb_latency: cycles=%0d round=%0d, want 81/10", n, round_idx);
        end
        vec++;
        if (ns != 10 || nl != 8) begin
            errs++; $display("FAIL ecb_shift_last: rkd_shift=%0d ie_last_round=%0d, want 10/8", ns, nl);
        end
        tick();
        vec++;
        if (job_done !== 1'b1 || state !== 3'd0 || out_valid !== 1'b0) begin
            errs++; $display("FAIL ecb_done: job_done=%b state=%0d out_valid=%b, want 1/0/0", job_done, state, out_valid);
        end
        tick();
        vec++;
        if (job_done !== 1'b0) begin
            errs++; $display("FAIL ecb_done_pulse: job_done=%b, want 0", job_done);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_ctr();
        int n, ns, nl, ni;
        int incs = 0;
        cfg_nk = 2'd0; cfg_inv = 1'b1; cfg_mode = 2'd2; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        vec++;
        if (state !== 3'd0 || key_ready !== 1'b1 || rkd_shift !== 1'b0) begin
            errs++; $display("FAIL ctr_cfg: state=%0d key_ready=%b rkd_shift=%b, want 0/1/0", state, key_ready, rkd_shift);
        end
        out_ready = 1'b1;
        start_job(16'd2);
        for (int b = 0; b < 2; b++) begin
            wait_in(n);
            push_block();
            incs += int'(ctr_inc);
            vec++;
            if (ctr_inc !== 1'b1 || chain_xor_out !== 1'b1 || chain_xor_in !== 1'b0) begin
                errs++; $display("FAIL ctr_blk%0d: ctr_inc=%b cxo=%b cxi=%b, want 1/1/0", b, ctr_inc, chain_xor_out, chain_xor_in);
            end
            wait_out(n, ns, nl, ni);
            incs += ni;
            vec++;
            if (n != 81) begin
                errs++; $display("FAIL ctr_latency%0d: cycles=%0d, want 81", b, n);
            end
            tick();
            vec++;
            if (job_done !== (b == 1) || state !== ((b == 1) ? 3'd0 : 3'd3)) begin
                errs++; $display("FAIL ctr_accept%0d: job_done=%b state=%0d, want %b/%0d",
                                 b, job_done, state, b == 1, (b == 1) ? 0 : 3);
            end
        end
        vec++;
        if (incs != 2) begin
            errs++; $display("FAIL ctr_inc_count: pulses=%0d, want 2", incs);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int n = 0;
        int seen = 0;
        start_job(16'd2);
        push_block();
        while (round_idx !== 4'd5 && n < 200) begin
            tick();
            n++;
        end
        vec++;
        if (round_idx !== 4'd5) begin
            errs++; $display("FAIL abort_reach: round=%0d, want 5", round_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vec++;
        if (state !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || round_idx !== 4'd0 ||
            job_done !== 1'b0 || key_ready !== 1'b1) begin
            errs++; $display("FAIL abort_state: state=%0d ov=%b ir=%b round=%0d done=%b kr=%b, want 0/0/0/0/0/1",
                             state, out_valid, in_ready, round_idx, job_done, key_ready);
        end
        repeat (100) begin
            tick();
            seen += int'(out_valid) + int'(job_done) + int'(state != 3'd0);
        end
        vec++;
        if (seen != 0) begin
            errs++; $display("FAIL abort_quiet: activity samples=%0d, want 0", seen);
        end
    endtask

    task automatic test_abort_vs_accept();
        int n, ns, nl, ni;
        start_job(16'd1);
        push_block();
        wait_out(n, ns, nl, ni);
        out_ready = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        vec++;
        if (n != 81 || job_done !== 1'b0 || state !== 3'd0 || out_valid !== 1'b0) begin
            errs++; $display("FAIL abort_accept: cycles=%0d done=%b state=%0d ov=%b, want 81/0/0/0",
                             n, job_done, state, out_valid);
        end
    endtask

    task automatic test_cbc_dec();
        int n, ns, nl, ni;
        int dones = 0;
        int held;
        cfg_nk = 2'd2; cfg_inv = 1'b1; cfg_mode = 2'd1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        vec++;
        if (state !== 3'd1 || rkd_inv_flag !== 1'b1 || rkd_shift !== 1'b1 || key_ready !== 1'b0) begin
            errs++; $display("FAIL inv_enter: state=%0d flag=%b shift=%b kr=%b, want 1/1/1/0",
                             state, rkd_inv_flag, rkd_shift, key_ready);
        end
        tick();
        vec++;
        if (state !== 3'd1 || rkd_shift !== 1'b0) begin
            errs++; $display("FAIL inv_hold: state=%0d shift=%b, want 1/0", state, rkd_shift);
        end
        tick();
        vec++;
        if (state !== 3'd0 || rkd_inv_flag !== 1'b1) begin
            errs++; $display("FAIL inv_exit: state=%0d flag=%b, want 0/1", state, rkd_inv_flag);
        end
        test_key_expand(3, 1'b1);
        start_job(16'd3);
        for (int b = 0; b < 3; b++) begin
            wait_in(n);
            vec++;
            if (in_ready !== 1'b1) begin
                errs++; $display("FAIL cbc_in%0d: in_ready=%b, want 1", b, in_ready);
            end
            push_block();
            vec++;
            if (chain_xor_out !== 1'b1 || chain_xor_in !== 1'b0) begin
                errs++; $display("FAIL cbc_chain%0d: cxo=%b cxi=%b, want 1/0", b, chain_xor_out, chain_xor_in);
            end
            wait_out(n, ns, nl, ni);
            vec++;
            if (n != 113) begin
                errs++; $display("FAIL cbc_latency%0d: cycles=%0d, want 113", b, n);
            end
            if (b == 1) begin
                held = 0;
                repeat (5) begin
                    tick();
                    held += int'(out_valid) + int'(job_done);
                end
                vec++;
                if (held != 5 || state !== 3'd5) begin
                    errs++; $display("FAIL cbc_backpressure: held=%0d state=%0d, want 5/5", held, state);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            dones += int'(job_done);
            vec++;
            if (out_valid !== 1'b0 || state !== ((b == 2) ? 3'd0 : 3'd3)) begin
                errs++; $display("FAIL cbc_accept%0d: ov=%b state=%0d, want 0/%0d", b, out_valid, state, (b == 2) ? 0 : 3);
            end
        end
        vec++;
        if (dones != 1 || job_done !== 1'b1) begin
            errs++; $display("FAIL cbc_job_done: pulses=%0d last=%b, want 1/1", dones, job_done);
        end
    endtask

    task automatic test_reset_midjob();
        start_job(16'd1);
        push_block();
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (state !== 3'd0 || key_ready !== 1'b0 || round_idx !== 4'd0 || ie_load !== 1'b1 || rkd_inv_flag !== 1'b0) begin
            errs++; $display("FAIL reset_mid: state=%0d kr=%b round=%0d ie_load=%b flag=%b, want 0/0/0/1/0",
                             state, key_ready, round_idx, ie_load, rkd_inv_flag);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_nk = 2'd0; cfg_inv = 1'b0; cfg_mode = 2'd0;
        ke_req = 1'b0; ke_last = 1'b0; job_start = 1'b0; job_blocks = 16'd0;
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        test_reset();
        test_job_err(16'd4, "err_no_key");
        test_key_expand(2, 1'b0);
        test_job_err(16'd0, "err_zero_blocks");
        test_ecb_single();
        test_ctr();
        test_abort();
        test_abort_vs_accept();
        test_cbc_dec();
        test_reset_midjob();
        test_job_err(16'd1, "err_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
